// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// master: the apb_master view; slave: the user + APB slave side.
interface apb_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic [3:0] paddr;
   logic [7:0] pwdata;
   logic       pwrite;
   logic       psel;
   logic       penable;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             paddr, pwdata, pwrite, psel, penable
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             paddr, pwdata, pwrite, psel, penable
   );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: command handshake in, one-cycle response pulse out.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer, cmd_ready=1
// SETUP  | psel=1, penable=0, always one cycle
// ACCESS | psel=1, penable=1, waiting for pready (or watchdog)
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic          pclk,
   input logic          presetn,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t     state, state_nxt;
   logic [3:0] paddr_q;
   logic [7:0] pwdata_q;
   logic       pwrite_q;
   logic       rsp_valid_q;
   logic [7:0] rsp_rdata_q;
   logic       rsp_err_q;
   logic       cmd_ready, psel, penable;
   logic       accept, done, timeout_hit;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) state_nxt = SETUP;
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (bus.pready) begin
               cmd_ready = 1'b1;
               done      = 1'b1;
               state_nxt = bus.cmd_valid ? SETUP : IDLE;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = bus.cmd_valid & cmd_ready;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state       <= IDLE;
         paddr_q     <= 4'h0;
         pwdata_q    <= 8'h00;
         pwrite_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         rsp_valid_q <= done | timeout_hit;
         if (accept) begin
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
            pwrite_q <= bus.cmd_write;
         end
         // Read data is only forwarded for clean reads; writes and errors report zero.
         if (done) begin
            rsp_err_q   <= bus.pslverr;
            rsp_rdata_q <= (!pwrite_q && !bus.pslverr) ? bus.prdata : 8'h00;
         end else if (timeout_hit) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 8'h00;
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       rsp_timeout_q;

   // Counter sits at zero outside ACCESS, so every ACCESS entry starts from a clean count.
   assign timeout_hit = (state == ACCESS) && !bus.pready &&
                        (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wait_cnt      <= 8'h00;
         rsp_timeout_q <= 1'b0;
      end else begin
         if (state != ACCESS)  wait_cnt <= 8'h00;
         else if (!bus.pready) wait_cnt <= wait_cnt + 8'h01;
         if (done)             rsp_timeout_q <= 1'b0;
         else if (timeout_hit) rsp_timeout_q <= 1'b1;
      end
   end

   assign bus.rsp_timeout = rsp_timeout_q;
`else
   assign timeout_hit     = 1'b0;
   assign bus.rsp_timeout = 1'b0;
`endif

   assign bus.cmd_ready = cmd_ready;
   assign bus.psel      = psel;
   assign bus.penable   = penable;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, sets the ACCESS-phase wait-cycle limit (range 1..255; used only with APB_TIMEOUT_EN).
REQ-002 pclk  input  1  APB clock; all state changes on its rising edge.
REQ-003 presetn  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  user requests a transfer.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  4  transfer address.
REQ-008 cmd_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse, transfer complete.
REQ-010 rsp_rdata  output  8  read data; valid with rsp_valid.
REQ-011 rsp_err  output  1  slave error or timeout; valid with rsp_valid.
REQ-012 rsp_timeout  output  1  transfer aborted by watchdog; valid with rsp_valid.
REQ-013 paddr  output  4  APB address.
REQ-014 pwdata  output  8  APB write data.
REQ-015 pwrite  output  1  APB direction.
REQ-016 psel  output  1  APB select.
REQ-017 penable  output  1  APB enable.
REQ-018 prdata  input  8  APB read data.
REQ-019 pready  input  1  slave ready.
REQ-020 pslverr  input  1  slave error; sampled only with pready in ACCESS.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, SETUP and ACCESS, with IDLE as the reset state.
REQ-022 cmd_ready SHALL be 1 in IDLE, and in ACCESS during a cycle with pready=1 (back-to-back); otherwise 0.
REQ-023 A handshake (cmd_valid & cmd_ready) at edge T SHALL register cmd_addr/cmd_wdata/cmd_write into paddr/pwdata/pwrite and enter SETUP at T.
REQ-024 SETUP: psel=1, penable=0; next edge unconditionally enters ACCESS; pready in SETUP ignored.
REQ-025 ACCESS: psel=1, penable=1; remain while pready=0.
REQ-026 paddr, pwdata and pwrite SHALL stay constant from SETUP through the final ACCESS cycle.
REQ-027 On the edge where pready=1 in ACCESS: rsp_valid=1 for the following cycle only; rsp_err=pslverr; rsp_rdata=prdata when read and pslverr=0, else 8'h00; rsp_timeout=0.
REQ-028 On that same edge, the next state is SETUP if a new command is accepted (REQ-022), else IDLE (psel=0, penable=0).
REQ-029 IDLE and state transitions SHALL not alter rsp_rdata/rsp_err between responses (hold last value); rsp_valid=0 except per REQ-027/REQ-033.
REQ-030 Minimum latency: handshake edge T -> SETUP cycle after T, ACCESS next, rsp_valid in cycle after the pready edge (3 cycles zero-wait).

Reset
REQ-031 presetn=0 SHALL immediately force state IDLE and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout to 0; cmd_ready=1 after release.
REQ-032 Reset asserted mid-transfer SHALL abort it with no rsp_valid generated for it.

Configuration
REQ-033 With APB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; when it reaches TIMEOUT_CYCLES with pready=0, the block SHALL return to IDLE and pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=8'h00.
REQ-034 Without APB_TIMEOUT_EN, no counter exists, ACCESS waits indefinitely for pready, and rsp_timeout SHALL be tied to 0.

Verification
REQ-035 Write addr 4'h3 data 8'hA5, pready=1 in first ACCESS -> psel rises cycle T+1, penable T+2, rsp_valid T+3, rsp_err=0.
REQ-036 Read addr 4'h7, slave returns 8'h3C after 2 wait cycles -> ACCESS lasts 3 cycles, paddr stable, rsp_rdata=8'h3C, rsp_err=0.
REQ-037 Read with pready=1, pslverr=1, prdata=8'hFF -> rsp_err=1, rsp_rdata=8'h00.
REQ-038 cmd_valid held high for two writes, zero-wait -> second SETUP directly follows first ACCESS, psel never drops, two rsp_valid pulses 2 cycles apart.
REQ-039 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, then IDLE.
REQ-040 presetn pulsed low during ACCESS -> psel/penable 0 immediately, no rsp_valid, next command completes normally.
